// File: rtl/sram_arbiter_if.sv
// Bus bundle between the CPU-side ports, the shared RAM and sram_arbiter.
// Every field of the instruction, data and RAM ports lives here; clk/rst stay plain ports.
`timescale 1ns/1ps
`ifndef SRAM_ARBITER_BUS_DEFS
`define SRAM_ARBITER_BUS_DEFS
`define ADDR_BUS [31:0]
`define DATA_BUS [31:0]
`endif

// Handshake: a requester raises *_req with stable address/data and keeps it high until the
// one-cycle *_ready pulse; *_err and *_rdata are valid with that pulse. A req still high in
// the cycle after ready is a fresh request.
interface sram_arbiter_if;
  logic           inst_req;
  logic `ADDR_BUS inst_addr;
  logic           inst_ready;
  logic `DATA_BUS inst_rdata;
  logic           inst_err;

  logic           data_req;
  logic [3:0]     data_we;
  logic `ADDR_BUS data_addr;
  logic `DATA_BUS data_wdata;
  logic           data_ready;
  logic `DATA_BUS data_rdata;
  logic           data_err;

  logic           ram_en;
  logic [3:0]     ram_write_sel;
  logic `ADDR_BUS ram_addr;
  logic `DATA_BUS ram_wdata;
  logic `DATA_BUS ram_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
    input  inst_ready, inst_rdata, inst_err, data_ready, data_rdata, data_err,
           ram_en, ram_write_sel, ram_addr, ram_wdata
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
    output inst_ready, inst_rdata, inst_err, data_ready, data_rdata, data_err,
           ram_en, ram_write_sel, ram_addr, ram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Serialises instruction-fetch and data requests onto one single-port RAM.
// Define ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
`timescale 1ns/1ps
`ifndef SRAM_ARBITER_BUS_DEFS
`define SRAM_ARBITER_BUS_DEFS
`define ADDR_BUS [31:0]
`define DATA_BUS [31:0]
`endif

module sram_arbiter #(
  parameter logic [31:0] RAM_BYTES = 32'd512
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t         state;
  logic           sel_data;
  logic `ADDR_BUS addr_q;
  logic `DATA_BUS wdata_q;
  logic [3:0]     we_q;
  logic           ram_en_q;
  logic [3:0]     ram_sel_q;
  logic           inst_ready_q;
  logic           inst_err_q;
  logic `DATA_BUS inst_rdata_q;
  logic           data_ready_q;
  logic           data_err_q;
  logic `DATA_BUS data_rdata_q;
`ifdef ARBITER_ROUND_ROBIN_EN
  logic           last_data;
`endif

  logic           grant_data;
  logic `ADDR_BUS req_addr;
  logic           req_err;

  always_comb begin
`ifdef ARBITER_ROUND_ROBIN_EN
    // On contention the port that did not win last time gets the RAM.
    grant_data = bus.data_req && (!bus.inst_req || !last_data);
`else
    grant_data = bus.data_req;
`endif
    req_addr = grant_data ? bus.data_addr : bus.inst_addr;
    req_err  = (req_addr >= RAM_BYTES) || (req_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sel_data     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= '0;
      ram_en_q     <= 1'b0;
      ram_sel_q    <= '0;
      inst_ready_q <= 1'b0;
      inst_err_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_ready_q <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_data    <= 1'b0;
`endif
    end else begin
      inst_ready_q <= 1'b0;
      inst_err_q   <= 1'b0;
      data_ready_q <= 1'b0;
      data_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.inst_req || bus.data_req) begin
            sel_data <= grant_data;
            addr_q   <= req_addr;
            we_q     <= grant_data ? bus.data_we : 4'd0;
            wdata_q  <= grant_data ? bus.data_wdata : '0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_data <= grant_data;
`endif
            if (req_err) begin
              // Illegal accesses complete straight away and never enable the RAM.
              state <= RESP;
              if (grant_data) begin
                data_ready_q <= 1'b1;
                data_err_q   <= 1'b1;
                data_rdata_q <= '0;
              end else begin
                inst_ready_q <= 1'b1;
                inst_err_q   <= 1'b1;
                inst_rdata_q <= '0;
              end
            end else begin
              state     <= ACCESS;
              ram_en_q  <= 1'b1;
              ram_sel_q <= grant_data ? bus.data_we : 4'd0;
            end
          end
        end
        ACCESS: begin
          ram_en_q <= 1'b0;
          if (we_q != 4'd0) begin
            // Byte select stays up through HOLD so the RAM's delayed commit sees it.
            state <= HOLD;
          end else begin
            state <= RESP;
            if (sel_data) begin
              data_ready_q <= 1'b1;
              data_rdata_q <= bus.ram_rdata;
            end else begin
              inst_ready_q <= 1'b1;
              inst_rdata_q <= bus.ram_rdata;
            end
          end
        end
        HOLD: begin
          ram_sel_q    <= '0;
          state        <= RESP;
          data_ready_q <= sel_data;
          inst_ready_q <= !sel_data;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.inst_ready    = inst_ready_q;
  assign bus.inst_err      = inst_err_q;
  assign bus.inst_rdata    = inst_rdata_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.data_err      = data_err_q;
  assign bus.data_rdata    = data_rdata_q;
  assign bus.ram_en        = ram_en_q;
  assign bus.ram_write_sel = ram_sel_q;
  assign bus.ram_addr      = addr_q;
  assign bus.ram_wdata     = wdata_q;
  assign busy              = (state != IDLE);
  assign state_dbg         = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, hand-written multi-cycle sequences and random traffic
// checked against a word-array memory model with the access-latency rules.
`timescale 1ns/1ps
`ifndef SRAM_ARBITER_BUS_DEFS
`define SRAM_ARBITER_BUS_DEFS
`define ADDR_BUS [31:0]
`define DATA_BUS [31:0]
`endif

module tb_sram_arbiter;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] state_dbg;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM with delayed write commit ----------------
  logic [31:0] mem [128];
  bit          wr_pend = 1'b0;

  assign bus.ram_rdata = mem[bus.ram_addr[8:2]];

  always @(posedge clk) begin
    if (wr_pend && bus.ram_write_sel != 4'd0) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_write_sel[b]) mem[bus.ram_addr[8:2]][8*b +: 8] = bus.ram_wdata[8*b +: 8];
    end
    wr_pend <= bus.ram_en && (bus.ram_write_sel != 4'd0);
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [128];
  logic [31:0] held_inst;
  logic [31:0] held_data;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {22'd0, bus.inst_ready, bus.inst_rdata, bus.inst_err, bus.data_ready, bus.data_rdata,
            bus.data_err, bus.ram_en, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata, busy};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge during an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic do_access(input bit is_data, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err,
                           output logic [31:0] rdata, output bit en_seen, output bit extra,
                           output int sel_hold, output int busy_cnt);
    bit done;
    lat = 0; err = 1'bx; rdata = 'x; en_seen = 0; extra = 0; sel_hold = 0; busy_cnt = 0; done = 0;
    if (is_data) begin
      bus.data_req = 1'b1; bus.data_we = we; bus.data_addr = addr; bus.data_wdata = wdata;
    end else begin
      bus.inst_req = 1'b1; bus.inst_addr = addr;
    end
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.ram_en) en_seen = 1;
      if (busy) busy_cnt++;
      if (we != 0 && bus.ram_write_sel == we && bus.ram_addr == addr && bus.ram_wdata == wdata)
        sel_hold++;
      if (is_data ? bus.inst_ready : bus.data_ready) extra = 1;
      if (is_data ? bus.data_ready : bus.inst_ready) begin
        done  = 1;
        err   = is_data ? bus.data_err : bus.inst_err;
        rdata = is_data ? bus.data_rdata : bus.inst_rdata;
      end
    end
    if (!done) lat = 99;
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    @(negedge clk);
    if (bus.inst_ready || bus.data_ready) extra = 1;
    if (busy) busy_cnt++;
  endtask

  // One transaction checked against the model; the model is then advanced.
  task automatic txn(input bit is_data, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat, output logic err,
                     output logic [31:0] rdata);
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          en_seen, extra;
    int          sel_hold, busy_cnt;
    exp_err = (addr >= 32'd512) || (addr[1:0] != 2'b00);
    exp_lat = exp_err ? 1 : ((we != 0) ? 3 : 2);
    if (exp_err) exp_rdata = 32'd0;
    else if (we != 0) exp_rdata = held_data;
    else exp_rdata = ref_mem[addr[8:2]];
    do_access(is_data, we, addr, wdata, lat, err, rdata, en_seen, extra, sel_hold, busy_cnt);
    check("latency", lat, exp_lat);
    check("err", err, exp_err);
    check("rdata", rdata, exp_rdata);
    check("ram_en_seen", en_seen, !exp_err);
    check("stray_ready", extra, 0);
    check("write_hold_cycles", sel_hold, (!exp_err && we != 0) ? 2 : 0);
    check("busy_cycles", busy_cnt, exp_lat);
    if (is_data) held_data = exp_rdata; else held_inst = exp_rdata;
    if (!exp_err && we != 0)
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[addr[8:2]][8*b +: 8] = wdata[8*b +: 8];
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_data;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          k, cyc, prev;
    bit          exp_d, seen_inst, seen_ready;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_val [3];

    vecs[0]  = '{0, 4'h0, 32'h010, 32'h0,        2, 0, 32'h11223344};
    vecs[1]  = '{1, 4'h2, 32'h020, 32'hAABBCCDD, 3, 0, 32'h00000000};
    vecs[2]  = '{1, 4'h0, 32'h020, 32'h0,        2, 0, 32'h0000CC00};
    vecs[3]  = '{1, 4'h0, 32'h200, 32'h0,        1, 1, 32'h00000000};
    vecs[4]  = '{0, 4'h0, 32'h006, 32'h0,        1, 1, 32'h00000000};
    vecs[5]  = '{1, 4'hF, 32'h030, 32'hCAFEF00D, 3, 0, 32'h00000000};
    vecs[6]  = '{0, 4'h0, 32'h030, 32'h0,        2, 0, 32'hCAFEF00D};
    vecs[7]  = '{1, 4'h9, 32'h1FC, 32'h12345678, 3, 0, 32'h00000000};
    vecs[8]  = '{1, 4'h0, 32'h1FC, 32'h0,        2, 0, 32'h12000078};
    vecs[9]  = '{1, 4'hF, 32'h1FD, 32'h0,        1, 1, 32'h00000000};
    vecs[10] = '{1, 4'h0, 32'h1FC, 32'h0,        2, 0, 32'h12000078};
    vecs[11] = '{0, 4'h0, 32'h1FC, 32'h0,        2, 0, 32'h12000078};

    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    held_inst = 0;
    held_data = 0;

    rst = 1'b0;
    bus.inst_req = 0; bus.inst_addr = 0;
    bus.data_req = 0; bus.data_we = 0; bus.data_addr = 0; bus.data_wdata = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 160'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table: constant expectations plus model checks.
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rdata);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_err", i), err, vecs[i].err);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
    end

    // Reset during HOLD of a write to 0x30: write aborted, no ready, outputs cleared.
    bus.data_req = 1; bus.data_we = 4'hF; bus.data_addr = 32'h30; bus.data_wdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("hold_signals", {bus.ram_en, bus.ram_write_sel, bus.ram_addr}, {1'b0, 4'hF, 32'h30});
    rst = 1'b0;
    #1;
    check("reset_mid_outputs", all_outs(), 160'd0);
    bus.data_req = 0;
    seen_ready = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.data_ready || bus.inst_ready) seen_ready = 1;
    end
    check("reset_held_outputs", all_outs(), 160'd0);
    rst = 1'b1;
    held_inst = 0;
    held_data = 0;
    @(negedge clk);
    if (bus.data_ready) seen_ready = 1;
    check("reset_no_ready", seen_ready, 0);

    // Contention: both ports request continuously.
    bus.inst_req = 1; bus.inst_addr = 32'h10;
    bus.data_req = 1; bus.data_we = 0; bus.data_addr = 32'h20;
    k = 0; cyc = 0; seen_inst = 0;
    while (k < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.data_ready || bus.inst_ready) begin
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_d = (k % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        check($sformatf("cont%0d_port", k), {bus.data_ready, bus.inst_ready}, {exp_d, !exp_d});
        check($sformatf("cont%0d_cycle", k), cyc, 3 * k + 2);
        if (bus.data_ready) check($sformatf("cont%0d_rdata", k), bus.data_rdata, 32'h0000CC00);
        else begin
          check($sformatf("cont%0d_rdata", k), bus.inst_rdata, 32'h11223344);
          seen_inst = 1;
        end
        k++;
      end
    end
    bus.inst_req = 0;
    bus.data_req = 0;
    check("cont_count", k, 4);
    held_data = 32'h0000CC00;
    if (seen_inst) held_inst = 32'h11223344;
    @(negedge clk);

    // Old value survives the aborted write.
    txn(1, 4'h0, 32'h30, 32'h0, lat, err, rdata);
    check("reread_0x30", rdata, 32'hCAFEF00D);

    // Back-to-back reads with data_req held and the address moved after each ready.
    b2b_addr = '{32'h0, 32'h4, 32'h8};
    b2b_val  = '{32'h01020304, 32'h55667788, 32'h9ABCDEF0};
    for (int i = 0; i < 3; i++) txn(1, 4'hF, b2b_addr[i], b2b_val[i], lat, err, rdata);
    bus.data_req = 1; bus.data_we = 0; bus.data_addr = b2b_addr[0];
    k = 0; cyc = 0; prev = 0;
    while (k < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.data_ready) begin
        check($sformatf("b2b%0d_rdata", k), bus.data_rdata, b2b_val[k]);
        check($sformatf("b2b%0d_gap", k), cyc - prev, (k == 0) ? 2 : 3);
        prev = cyc;
        k++;
        if (k < 3) bus.data_addr = b2b_addr[k];
      end
    end
    bus.data_req = 0;
    check("b2b_count", k, 3);
    held_data = b2b_val[2];
    @(negedge clk);

    // Random single-port traffic against the model.
    for (int n = 0; n < 40; n++) begin
      bit          is_d;
      int unsigned r;
      logic [31:0] a;
      logic [3:0]  w;
      is_d = $urandom_range(0, 1) != 0;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom_range(128, 600) * 4;
      else if (r == 1) a = $urandom_range(0, 127) * 4 + $urandom_range(1, 3);
      else a = $urandom_range(0, 127) * 4;
      w = (is_d && $urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      txn(is_d, w, a, $urandom, lat, err, rdata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single-port simulation RAM between the instruction-fetch and data-memory stages of the CPU test bench. It accepts independent request/ready handshakes from both ports and serialises them into RAM transactions, each with a fixed cycle sequence. It holds write address, data and byte select stable long enough for the RAM's delayed write commit. Accesses outside the RAM window or misaligned are rejected without touching the RAM.

## Interface
- kRamBytes, 512: byte size of the RAM window. A legal address is below kRamBytes and word-aligned (addr[1:0]==0).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset. Asynchronous, active-low.
- inst_req  in  1  instruction read request; held until inst_ready.
- inst_addr  in  `ADDR_BUS  instruction byte address; stable while inst_req.
- inst_ready  out  1  one-cycle completion pulse.
- inst_rdata  out  `DATA_BUS  read data; valid from inst_ready, held until next inst completion.
- inst_err  out  1  valid with inst_ready; 1 = illegal address.
- data_req  in  1  data request; held until data_ready.
- data_we  in  4  byte write select. 0 means read; bit0 selects data[7:0] … bit3 selects data[31:24].
- data_addr  in  `ADDR_BUS  data byte address.
- data_wdata  in  `DATA_BUS  write data.
- data_ready  out  1  one-cycle completion pulse.
- data_rdata  out  `DATA_BUS  read data. Valid from data_ready; unchanged by write completions.
- data_err  out  1  valid with data_ready.
- ram_en  out  1  RAM enable.
- ram_write_sel  out  4  RAM byte write select.
- ram_addr  out  `ADDR_BUS  RAM address.
- ram_wdata  out  `DATA_BUS  RAM write data.
- ram_rdata  in  `DATA_BUS  RAM combinational read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, HOLD, RESP.
- **IDLE**
  - If either req is high, select a winner and latch its addr, we and wdata. The instruction port has we=0 and wdata=0.
  - Set the latched error flag: err = (addr >= kRamBytes) || addr[1:0] != 0.
  - Next state: RESP if err, otherwise ACCESS.
- **ACCESS**
  - Drive ram_en=1, with ram_addr, ram_write_sel and ram_wdata taken from the latches.
  - Read: capture ram_rdata into the winner's rdata register at the end of the cycle, then go to RESP.
  - Write: go to HOLD.
- **HOLD** (writes only)
  - ram_en=0.
  - ram_addr, ram_write_sel and ram_wdata stay at the latched values so the RAM commits the write on the following edge.
  - Next state: RESP.
- **RESP**
  - Pulse the winner's ready for one cycle and drive its err. On err, its rdata register is loaded with 0.
  - Next state: IDLE.
- Outside ACCESS and HOLD: ram_en=0, ram_write_sel=0. ram_addr and ram_wdata keep their last latched values.
- The loser keeps its req asserted and is considered again in the next IDLE.
- A port that re-asserts, or keeps, req after its ready is treated as a new request.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled high.
  - Legal read: ACCESS in cycle 1, ready in cycle 2.
  - Legal write: ACCESS 1, HOLD 2, ready in cycle 3.
  - Illegal access: ready with err=1 in cycle 1; ram_en is never asserted.
- Minimum spacing between grants is one IDLE cycle. Back-to-back reads therefore give one completion every 3 cycles.
- On reset (rst low, asynchronous):
  - State returns to IDLE; all outputs and latches go to 0.
  - The round-robin pointer (if compiled in) returns to "last = inst".
  - Any in-flight transaction is dropped with no ready pulse. A write in HOLD is aborted.
- Requests with req high during reset are served normally after rst rises.

## Configuration
- ARBITER_ROUND_ROBIN_EN defined: when both ports request in IDLE, the port not granted last time wins. The pointer updates on every grant, error grants included. After reset, data wins the first contention.
- Not defined: fixed priority, data always beats inst. Instruction starvation under continuous data requests is accepted behaviour.

## Test plan
- **Single read:** preload word 0x11223344 at 0x10. inst_req, addr 0x10 → inst_ready in cycle 2, inst_rdata=0x11223344, inst_err=0, busy high cycles 1–2.
- **Byte write:** data_we=4'b0010, addr 0x20, wdata 0xAABBCCDD over word 0x00000000, then read 0x20 → data_rdata=0x0000CC00. Write ready in cycle 3. ram_addr/ram_write_sel stable through HOLD.
- **Contention:** both req high continuously.
  - Without macro: all grants go to data.
  - With ARBITER_ROUND_ROBIN_EN: grants alternate data, inst, data, …, one completion every 3 or 4 cycles.
- **Illegal access:** data read at 0x200 and inst read at 0x06 → ready in cycle 1, err=1, rdata=0, ram_en never high.
- **Reset mid-write:** assert rst low during HOLD of a write to 0x30 → no data_ready. Re-read 0x30 after reset returns the old value. All outputs read 0 while rst is low.
- **Back-to-back:** data_req held through 3 reads at 0x0, 0x4, 0x8 with the address changed after each ready → three ready pulses 3 cycles apart, each with correct data.
